// File: rtl/mem_dump_ctrl_pkg.sv
// Shared encodings for the data-memory port and the memory-dump controller FSM.
package mem_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_WR_BYTE = 2'b00,
    MEM_WR_HALF = 2'b01,
    MEM_WR_WORD = 2'b10
  } mem_wr_src_e;

  typedef enum logic [2:0] {
    MEM_RD_BYTE  = 3'b000,
    MEM_RD_HALF  = 3'b001,
    MEM_RD_WORD  = 3'b010,
    MEM_RD_UBYTE = 3'b011,
    MEM_RD_UHALF = 3'b100
  } mem_rd_src_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } dump_state_e;

endpackage

// File: rtl/mem_dump_ctrl.sv
// Arbitrates the data memory between the MEM stage and a debug dump that streams
// every word out over a valid/ready handshake while the pipeline is stalled.
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_pipe_wr_rd,
  input  logic [1:0]               i_pipe_wr_src,
  input  logic [2:0]               i_pipe_rd_src,
  input  logic [MEM_ADDR_SIZE-1:0] i_pipe_addr,
  input  logic [IO_BUS_SIZE-1:0]   i_pipe_data,
  input  logic                     i_dump_start,
  input  logic                     i_dump_ready,
  input  logic [IO_BUS_SIZE-1:0]   i_mem_rd,
  output logic                     o_mem_wr_rd,
  output logic [1:0]               o_mem_wr_src,
  output logic [2:0]               o_mem_rd_src,
  output logic [MEM_ADDR_SIZE-1:0] o_mem_addr,
  output logic [IO_BUS_SIZE-1:0]   o_mem_wr_data,
  output logic [IO_BUS_SIZE-1:0]   o_pipe_rd_data,
  output logic [IO_BUS_SIZE-1:0]   o_dump_data,
  output logic [MEM_ADDR_SIZE-1:0] o_dump_addr,
  output logic                     o_dump_valid,
  output logic                     o_dump_done,
  output logic                     o_pipe_stall
);

  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = '1;

  dump_state_e              state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [IO_BUS_SIZE-1:0]   data_q, data_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic                     valid_q, valid_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    data_d        = data_q;
    addr_d        = addr_q;
    valid_d       = valid_q;
    // Outside IDLE the dump owns the memory port as a read-only word reader.
    o_mem_wr_rd   = 1'b0;
    o_mem_wr_src  = MEM_WR_WORD;
    o_mem_rd_src  = MEM_RD_WORD;
    o_mem_addr    = ptr_q;
    o_mem_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        o_mem_wr_rd   = i_pipe_wr_rd;
        o_mem_wr_src  = i_pipe_wr_src;
        o_mem_rd_src  = i_pipe_rd_src;
        o_mem_addr    = i_pipe_addr;
        o_mem_wr_data = i_pipe_data;
        if (i_dump_start) begin
          state_d = READ;
          ptr_d   = '0;
        end
      end
      READ: begin
        data_d  = i_mem_rd;
        addr_d  = ptr_q;
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_dump_ready) begin
          valid_d = 1'b0;
          if (ptr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_pipe_rd_data = i_mem_rd;
  assign o_dump_data    = data_q;
  assign o_dump_addr    = addr_q;
  assign o_dump_valid   = valid_q;
  assign o_dump_done    = (state_q == DONE);
  assign o_pipe_stall   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Scoreboard bench for mem_dump_ctrl: directed dumps, back-pressure, reset abort.
module tb_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wr_rd;
  logic [1:0]  pipe_wr_src;
  logic [2:0]  pipe_rd_src;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        dump_start, dump_ready;
  logic [31:0] mem_rd;
  logic        mem_wr_rd;
  logic [1:0]  mem_wr_src;
  logic [2:0]  mem_rd_src;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wr_data, pipe_rd_data, dump_data;
  logic [4:0]  dump_addr;
  logic        dump_valid, dump_done, pipe_stall;

  always #5 clk = ~clk;

  mem_dump_ctrl #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_pipe_wr_rd(pipe_wr_rd), .i_pipe_wr_src(pipe_wr_src), .i_pipe_rd_src(pipe_rd_src),
    .i_pipe_addr(pipe_addr), .i_pipe_data(pipe_data),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .i_mem_rd(mem_rd),
    .o_mem_wr_rd(mem_wr_rd), .o_mem_wr_src(mem_wr_src), .o_mem_rd_src(mem_rd_src),
    .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .o_pipe_rd_data(pipe_rd_data),
    .o_dump_data(dump_data), .o_dump_addr(dump_addr), .o_dump_valid(dump_valid),
    .o_dump_done(dump_done), .o_pipe_stall(pipe_stall)
  );

  // Data memory: combinational read, synchronous write, optional pattern preload.
  logic [31:0] mem [32];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h11111111 * i;
    end else if (mem_wr_rd) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end
  assign mem_rd = mem[mem_addr];

  typedef struct { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int words_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.a = 5'(i);
      e.d = 32'h11111111 * i;
      q.push_back(e);
    end
  endtask

  // Monitor: pops on every accepted word, checks hold stability and done width.
  logic        prev_hold = 1'b0;
  logic        prev_done = 1'b0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold && !reset) begin
      check("hold_valid", {31'b0, dump_valid}, 32'd1);
      check("hold_addr", {27'b0, dump_addr}, {27'b0, prev_addr});
      check("hold_data", dump_data, prev_data);
    end
    if (dump_valid && dump_ready && !reset) begin
      words_seen++;
      if (q.size() == 0) begin
        check("unexpected_word", {27'b0, dump_addr}, 32'hFFFFFFFF);
      end else begin
        e = q.pop_front();
        check("word_addr", {27'b0, dump_addr}, {27'b0, e.a});
        check("word_data", dump_data, e.d);
      end
    end
    if (dump_done) begin
      done_cnt++;
      if (prev_done) check("done_width", 32'd2, 32'd1);
    end
    prev_done = dump_done;
    prev_hold = dump_valid && !dump_ready && !reset;
    prev_addr = dump_addr;
    prev_data = dump_data;
  end

  task automatic run_full(output int n);
    n = 0;
    dump_start = 1'b1;
    do begin
      @(posedge clk); n++; #1;
      dump_start = 1'b0;
    end while (!dump_done && n < 200);
  endtask

  task automatic wait_read(input logic [4:0] a);
    int n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!(pipe_stall && !dump_valid && !dump_done && mem_addr == a) && n < 300);
    if (n >= 300) check("wait_read_timeout", 32'(a), 32'hFFFFFFFF);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dump_done && n < 300) begin
      @(posedge clk); n++; #1;
    end
    check("done_seen", {31'b0, dump_done}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; pipe_wr_rd = 1'b0; pipe_wr_src = 2'b00; pipe_rd_src = 3'b000;
    pipe_addr = '0; pipe_data = '0; dump_start = 1'b0; dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, dump_valid}, 32'd0);
    check("rst_done", {31'b0, dump_done}, 32'd0);
    check("rst_stall", {31'b0, pipe_stall}, 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("rst_dump_addr", {27'b0, dump_addr}, 32'd0);
    reset = 1'b0;

    // Pass-through write in the first cycle after reset.
    pipe_wr_rd = 1'b1; pipe_wr_src = 2'b10; pipe_rd_src = 3'b001;
    pipe_addr = 5'd3; pipe_data = 32'hDEADBEEF;
    #1;
    check("pt_wr_rd", {31'b0, mem_wr_rd}, 32'd1);
    check("pt_wr_src", {30'b0, mem_wr_src}, 32'd2);
    check("pt_rd_src", {29'b0, mem_rd_src}, 32'd1);
    check("pt_addr", {27'b0, mem_addr}, 32'd3);
    check("pt_wr_data", mem_wr_data, 32'hDEADBEEF);
    check("pt_stall", {31'b0, pipe_stall}, 32'd0);
    @(posedge clk); #1;
    pipe_wr_rd = 1'b0; pipe_rd_src = 3'b010;
    #1;
    check("pt_mem3", mem[3], 32'hDEADBEEF);
    check("pt_rd_data", pipe_rd_data, 32'hDEADBEEF);
    check("pt_rd_src2", {29'b0, mem_rd_src}, 32'd2);

    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;

    // Full dump, ready held high.
    done_cnt = 0; words_seen = 0; push_all(); dump_ready = 1'b1;
    run_full(n);
    check("full_done_cycle", 32'(n), 32'd65);
    @(posedge clk); #1;
    check("full_stall_after", {31'b0, pipe_stall}, 32'd0);
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_words", 32'(words_seen), 32'd32);
    check("full_q_empty", 32'(q.size()), 32'd0);

    // Dump with blocked pipe write, 10-cycle back-pressure and a stray start.
    done_cnt = 0; words_seen = 0; push_all();
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    wait_read(5'd2);
    pipe_wr_rd = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hFFFFFFFF;
    #1;
    check("blk_wr_rd", {31'b0, mem_wr_rd}, 32'd0);
    check("blk_addr", {27'b0, mem_addr}, 32'd2);
    check("blk_stall", {31'b0, pipe_stall}, 32'd1);
    @(posedge clk); #1;
    check("blk_wr_rd2", {31'b0, mem_wr_rd}, 32'd0);
    pipe_wr_rd = 1'b0;
    wait_read(5'd7);
    dump_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, dump_valid}, 32'd1);
      check("bp_addr", {27'b0, dump_addr}, 32'd7);
      check("bp_data", dump_data, 32'h77777777);
    end
    dump_ready = 1'b1;
    wait_read(5'd20);
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    wait_done();
    @(posedge clk); #1;
    check("bp_done_cnt", 32'(done_cnt), 32'd1);
    check("bp_words", 32'(words_seen), 32'd32);
    check("bp_q_empty", 32'(q.size()), 32'd0);
    check("bp_mem5", mem[5], 32'h55555555);
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_restart", {31'b0, pipe_stall}, 32'd0);

    // Reset aborts mid-dump at word 12.
    done_cnt = 0; words_seen = 0; push_all();
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    wait_read(5'd12);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    pipe_addr = 5'd9;
    #1;
    check("abort_valid", {31'b0, dump_valid}, 32'd0);
    check("abort_stall", {31'b0, pipe_stall}, 32'd0);
    check("abort_dump_addr", {27'b0, dump_addr}, 32'd0);
    check("abort_dump_data", dump_data, 32'd0);
    check("abort_pt_addr", {27'b0, mem_addr}, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    words_seen = 0; push_all();
    run_full(n);
    check("restart_done_cycle", 32'(n), 32'd65);
    @(posedge clk); #1;
    check("restart_words", 32'(words_seen), 32'd32);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    check("restart_q_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
